// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mc_cu_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_IMMEX    = 4'd10,
        S_IMMWB    = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_NOR = 3'b011;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle. MC_CU_EXT_OPS_EN adds branch_ne/imm_zext.
interface mc_control_unit_if #(
    parameter int ULA_CTRL_W = 3
);
    logic [5:0]            op;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  iord;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic                  pc_write;
    logic                  branch;
    logic                  pc_en;
    logic [ULA_CTRL_W-1:0] ula_control;
    logic                  illegal;
    logic [3:0]            state;
`ifdef MC_CU_EXT_OPS_EN
    logic                  branch_ne;
    logic                  imm_zext;
`endif

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_write, branch, pc_en,
               ula_control, illegal, state
`ifdef MC_CU_EXT_OPS_EN
        , output branch_ne, imm_zext
`endif
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, pc_write, branch, pc_en,
               ula_control, illegal, state
`ifdef MC_CU_EXT_OPS_EN
        , input branch_ne, imm_zext
`endif
    );

endinterface

// File: rtl/alu_decoder.sv
// R-type funct decoder: ALU operation code plus a legality flag for the funct.
module alu_decoder
    import mc_cu_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] ula_o,
    output logic       legal_o
);

    always_comb begin
        ula_o   = ULA_ADD;
        legal_o = 1'b1;
        unique case (funct_i)
            FN_ADD:  ula_o = ULA_ADD;
            FN_SUB:  ula_o = ULA_SUB;
            FN_AND:  ula_o = ULA_AND;
            FN_OR:   ula_o = ULA_OR;
            FN_NOR:  ula_o = ULA_NOR;
            FN_SLT:  ula_o = ULA_SLT;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over the
// shared-ALU, single-memory datapath. Define MC_CU_EXT_OPS_EN for BNE/ANDI/ORI/SLTI.
module mc_control_unit
    import mc_cu_pkg::*;
#(
    parameter int ULA_CTRL_W = 3,
    parameter int MEM_WAIT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_unit_if.master  bus
);

    state_t state_q, state_d;
    logic   run_q;
    logic   ready;
    logic   fn_legal;
    logic   [2:0] fn_ula;
    logic   [2:0] ula3;
    logic   [ULA_CTRL_W-1:0] ula_full;
    logic   is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_bne, is_imm_ext, op_legal;
    logic   pc_write, branch, branch_ne, illegal;

    assign ready = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

    alu_decoder u_alu_decoder (
        .funct_i (bus.funct),
        .ula_o   (fn_ula),
        .legal_o (fn_legal)
    );

    assign is_r    = (bus.op == OP_RTYPE);
    assign is_lw   = (bus.op == OP_LW);
    assign is_sw   = (bus.op == OP_SW);
    assign is_beq  = (bus.op == OP_BEQ);
    assign is_j    = (bus.op == OP_J);
    assign is_addi = (bus.op == OP_ADDI);
`ifdef MC_CU_EXT_OPS_EN
    assign is_bne     = (bus.op == OP_BNE);
    assign is_imm_ext = (bus.op == OP_ANDI) || (bus.op == OP_ORI) || (bus.op == OP_SLTI);
`else
    assign is_bne     = 1'b0;
    assign is_imm_ext = 1'b0;
`endif
    assign op_legal = (is_r & fn_legal) | is_lw | is_sw | is_beq | is_bne | is_j |
                      is_addi | is_imm_ext;

    // IDLE waits one extra edge after reset release via run_q.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (run_q) state_d = S_FETCH;
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal)              state_d = S_FETCH;
                else if (is_r)              state_d = S_EXECUTE;
                else if (is_lw || is_sw)    state_d = S_MEMADR;
                else if (is_beq || is_bne)  state_d = S_BRANCH;
                else if (is_j)              state_d = S_JUMP;
                else                        state_d = S_IMMEX;
            end
            S_MEMADR:   state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_IMMEX:    state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REG;
        bus.pc_src     = PCSRC_ALU;
        pc_write       = 1'b0;
        branch         = 1'b0;
        branch_ne      = 1'b0;
        illegal        = 1'b0;
        ula3           = ULA_AND;
`ifdef MC_CU_EXT_OPS_EN
        bus.imm_zext   = 1'b0;
`endif
        unique case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                ula3          = ULA_ADD;
                bus.ir_write  = ready;
                pc_write      = ready;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMMSH2;
                ula3          = ULA_ADD;
                illegal       = ~op_legal;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                ula3          = ULA_ADD;
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_REG;
                ula3          = fn_ula;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = PCSRC_ALUOUT;
                ula3          = ULA_SUB;
                branch        = ~is_bne;
                branch_ne     = is_bne;
            end
            S_IMMEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                ula3          = ULA_ADD;
`ifdef MC_CU_EXT_OPS_EN
                if (bus.op == OP_ANDI) begin
                    ula3         = ULA_AND;
                    bus.imm_zext = 1'b1;
                end else if (bus.op == OP_ORI) begin
                    ula3         = ULA_OR;
                    bus.imm_zext = 1'b1;
                end else if (bus.op == OP_SLTI) begin
                    ula3         = ULA_SLT;
                end
`endif
            end
            S_IMMWB:    bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = PCSRC_JUMP;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ula_full      = '0;
        ula_full[2:0] = ula3;
    end

    assign bus.ula_control = ula_full;
    assign bus.pc_write    = pc_write;
    assign bus.branch      = branch;
    assign bus.illegal     = illegal;
    assign bus.pc_en       = pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero);
    assign bus.state       = state_q;
`ifdef MC_CU_EXT_OPS_EN
    assign bus.branch_ne   = branch_ne;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction step sequences model the expected
// control outputs every cycle, with randomized instructions and memory waits.
module tb_mc_control_unit;

    localparam int K_IDLE = 0, K_FETCH = 1, K_DECODE = 2, K_MEMADR = 3, K_MEMREAD = 4,
                   K_MEMWB = 5, K_MEMWRITE = 6, K_EXECUTE = 7, K_ALUWB = 8,
                   K_BRANCH = 9, K_IMMEX = 10, K_IMMWB = 11, K_JUMP = 12;

    localparam logic [5:0] T_R = 6'h00, T_LW = 6'h23, T_SW = 6'h2b, T_BEQ = 6'h04,
                           T_BNE = 6'h05, T_ADDI = 6'h08, T_ANDI = 6'h0c,
                           T_ORI = 6'h0d, T_SLTI = 6'h0a, T_J = 6'h02;

    localparam logic [5:0] FN_TAB [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
    localparam logic [2:0] UL_TAB [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};

    typedef struct packed {
        logic       idle;
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       pc_en;
        logic [2:0] ula;
        logic       illegal;
        logic       branch_ne;
        logic       imm_zext;
    } ov_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_memwb, n_writes, n_ill;
    logic br_pc_en;
    bit   exp_valid;
    ov_t  exp_v;
    int   exp_step;

    mc_control_unit_if #(.ULA_CTRL_W(3)) bus ();

    mc_control_unit #(.ULA_CTRL_W(3), .MEM_WAIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit funct_known(input logic [5:0] fn, output logic [2:0] ula);
        ula = 3'b000;
        for (int i = 0; i < 6; i++) begin
            if (FN_TAB[i] == fn) begin
                ula = UL_TAB[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit legal_instr(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] u;
        if (op == T_R) return funct_known(fn, u);
        if (op inside {T_LW, T_SW, T_BEQ, T_ADDI, T_J}) return 1'b1;
`ifdef MC_CU_EXT_OPS_EN
        if (op inside {T_BNE, T_ANDI, T_ORI, T_SLTI}) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit is_mem_step(input int k);
        return (k == K_FETCH) || (k == K_MEMREAD) || (k == K_MEMWRITE);
    endfunction

    // What the datapath controls must be during one step of an instruction.
    function automatic ov_t step_out(input int k, input logic [5:0] op, input logic [5:0] fn,
                                     input logic zero, input logic ready);
        ov_t o;
        logic [2:0] u;
        o = '0;
        case (k)
            K_IDLE:     o.idle = 1'b1;
            K_FETCH: begin
                o.mem_req = 1; o.alu_src_b = 2'b01; o.ula = 3'b010;
                o.ir_write = ready; o.pc_write = ready; o.pc_en = ready;
            end
            K_DECODE: begin
                o.alu_src_b = 2'b11; o.ula = 3'b010; o.illegal = !legal_instr(op, fn);
            end
            K_MEMADR:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.ula = 3'b010; end
            K_MEMREAD:  begin o.mem_req = 1; o.iord = 1; end
            K_MEMWB:    begin o.mem_to_reg = 1; o.reg_write = 1; end
            K_MEMWRITE: begin o.mem_req = 1; o.iord = 1; o.mem_write = 1; end
            K_EXECUTE: begin
                o.alu_src_a = 1;
                void'(funct_known(fn, u));
                o.ula = u;
            end
            K_ALUWB:    begin o.reg_dst = 1; o.reg_write = 1; end
            K_BRANCH: begin
                o.alu_src_a = 1; o.ula = 3'b110; o.pc_src = 2'b01;
                o.branch_ne = (op == T_BNE);
                o.branch = !o.branch_ne;
                o.pc_en = o.branch_ne ? !zero : zero;
            end
            K_IMMEX: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10;
                o.ula = (op == T_ANDI) ? 3'b000 : (op == T_ORI) ? 3'b001 :
                        (op == T_SLTI) ? 3'b111 : 3'b010;
                o.imm_zext = (op == T_ANDI) || (op == T_ORI);
            end
            K_IMMWB:    o.reg_write = 1;
            K_JUMP:     begin o.pc_src = 2'b10; o.pc_write = 1; o.pc_en = 1; end
            default:    o = '0;
        endcase
        return o;
    endfunction

    function automatic ov_t pack_dut();
        ov_t o;
        o.idle       = (bus.state == 4'd0);
        o.mem_req    = bus.mem_req;
        o.iord       = bus.iord;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.reg_write  = bus.reg_write;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.pc_src     = bus.pc_src;
        o.pc_write   = bus.pc_write;
        o.branch     = bus.branch;
        o.pc_en      = bus.pc_en;
        o.ula        = bus.ula_control[2:0];
        o.illegal    = bus.illegal;
`ifdef MC_CU_EXT_OPS_EN
        o.branch_ne  = bus.branch_ne;
        o.imm_zext   = bus.imm_zext;
`else
        o.branch_ne  = 1'b0;
        o.imm_zext   = 1'b0;
`endif
        return o;
    endfunction

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            ov_t act;
            act = pack_dut();
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL outputs step=%0d got=%h expected=%h t=%0t", exp_step, act, exp_v, $time);
            end
            if (bus.reg_write && bus.mem_to_reg) n_memwb++;
            if (bus.reg_write || bus.mem_write) n_writes++;
            if (bus.illegal) n_ill++;
            if (bus.branch) br_pc_en = bus.pc_en;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Runs one instruction from its FETCH; called just after a rising edge.
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic izero,
                             input int fw, input int mw, input int abort_at, output int ncyc);
        int steps[$];
        steps = {K_FETCH, K_DECODE};
        if (legal_instr(iop, ifn)) begin
            if (iop == T_R)                        steps = {steps, K_EXECUTE, K_ALUWB};
            else if (iop == T_LW)                  steps = {steps, K_MEMADR, K_MEMREAD, K_MEMWB};
            else if (iop == T_SW)                  steps = {steps, K_MEMADR, K_MEMWRITE};
            else if (iop == T_BEQ || iop == T_BNE) steps.push_back(K_BRANCH);
            else if (iop == T_J)                   steps.push_back(K_JUMP);
            else                                   steps = {steps, K_IMMEX, K_IMMWB};
        end
        ncyc = 0;
        foreach (steps[i]) begin
            int w;
            w = (steps[i] == K_FETCH) ? fw : is_mem_step(steps[i]) ? mw : 0;
            for (int c = 0; c <= w; c++) begin
                if (ncyc == abort_at) return;
                bus.op        = (steps[i] == K_FETCH) ? 6'($urandom) : iop;
                bus.funct     = (steps[i] == K_FETCH) ? 6'($urandom) : ifn;
                bus.zero      = (steps[i] == K_BRANCH) ? izero : 1'($urandom);
                bus.mem_ready = is_mem_step(steps[i]) ? (c == w) : 1'($urandom);
                exp_v     = step_out(steps[i], iop, ifn, izero, bus.mem_ready);
                exp_step  = steps[i];
                exp_valid = 1'b1;
                @(posedge clk);
                #1;
                ncyc++;
            end
        end
    endtask

    task automatic idle_cycle();
        exp_v     = step_out(K_IDLE, 6'h0, 6'h0, 1'b0, 1'b0);
        exp_step  = K_IDLE;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, b_memwb, b_wr, b_ill;
        logic [5:0] rop, rfn;
        logic [5:0] ops_tab [13];
        ov_t pin;
        checks = 0; failures = 0; n_memwb = 0; n_writes = 0; n_ill = 0;
        br_pc_en = 1'b0; exp_valid = 1'b0; exp_v = '0; exp_step = 0;
        ops_tab = '{T_R, T_R, T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_BNE, T_ANDI, T_ORI, T_SLTI, 6'h3f};
        rst_n = 1'b0;
        bus.op = 6'h0; bus.funct = 6'h0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset held, then released; FETCH arrives on the second edge.
        @(posedge clk); #1;
        repeat (3) idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        idle_cycle();
        chk("first_fetch_req_ir_pc", {29'd0, bus.mem_req, bus.ir_write, bus.pc_write}, 32'd7);

        // Model pins: hand-derived values.
        pin = step_out(K_EXECUTE, T_R, 6'h22, 1'b0, 1'b0);
        chk("pin_sub_ula", {29'd0, pin.ula}, 32'd6);
        pin = step_out(K_DECODE, 6'h3f, 6'h00, 1'b0, 1'b0);
        chk("pin_illegal_op", {31'd0, pin.illegal}, 32'd1);

        // LW with two not-ready cycles in MEMREAD.
        b_memwb = n_memwb;
        run_instr(T_LW, 6'h11, 1'b0, 0, 2, -1, nc);
        chk("lw_wait2_cycles", nc, 7);
        chk("lw_memwb_once", n_memwb - b_memwb, 1);
        chk("lw_back_in_fetch", {30'd0, bus.mem_req, bus.iord}, 32'd2);

        run_instr(T_R, 6'h22, 1'b0, 0, 0, -1, nc);
        chk("sub_cycles", nc, 4);

        run_instr(T_BEQ, 6'h05, 1'b1, 0, 0, -1, nc);
        chk("beq_taken_pc_en", {31'd0, br_pc_en}, 32'd1);
        chk("beq_taken_cycles", nc, 3);
        run_instr(T_BEQ, 6'h05, 1'b0, 0, 0, -1, nc);
        chk("beq_not_taken_pc_en", {31'd0, br_pc_en}, 32'd0);
        chk("beq_not_taken_cycles", nc, 3);

        b_ill = n_ill; b_wr = n_writes;
        run_instr(6'h3f, 6'h20, 1'b0, 0, 0, -1, nc);
        chk("illegal_op_cycles", nc, 2);
        run_instr(T_R, 6'h01, 1'b0, 0, 0, -1, nc);
        chk("illegal_funct_cycles", nc, 2);
        chk("illegal_pulses", n_ill - b_ill, 2);
        chk("illegal_no_writes", n_writes - b_wr, 0);

        run_instr(T_SW, 6'h00, 1'b0, 0, 0, -1, nc);
        chk("sw_cycles", nc, 4);
        run_instr(T_ADDI, 6'h00, 1'b0, 0, 0, -1, nc);
        chk("addi_cycles", nc, 4);
        run_instr(T_J, 6'h00, 1'b0, 0, 0, -1, nc);
        chk("j_cycles", nc, 3);

        // Reset dropped while MEMWRITE waits on memory.
        run_instr(T_SW, 6'h00, 1'b0, 1, 5, 4, nc);
        bus.op = T_SW; bus.mem_ready = 1'b0;
        exp_v = step_out(K_MEMWRITE, T_SW, 6'h00, 1'b0, 1'b0);
        exp_step = K_MEMWRITE;
        #1;
        chk("memwrite_before_reset", {31'd0, bus.mem_write}, 32'd1);
        rst_n = 1'b0;
        exp_v = step_out(K_IDLE, 6'h0, 6'h0, 1'b0, 1'b0);
        exp_step = K_IDLE;
        #1;
        chk("reset_async_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("reset_async_state", {28'd0, bus.state}, 32'd0);
        @(posedge clk); #1;
        idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        idle_cycle();

        // Randomized instruction stream with random memory waits.
        for (int n = 0; n < 200; n++) begin
            rop = ops_tab[$urandom_range(0, 12)];
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            rfn = 6'($urandom);
            if (rop == T_R && $urandom_range(0, 3) != 0) rfn = FN_TAB[$urandom_range(0, 5)];
            run_instr(rop, rfn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1, nc);
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
